// File: rtl/apb_interconnect.sv
//==============================================================================
// Module      : apb_interconnect
// Description : 1-to-NUM_SLAVES APB interconnect with region decode, response
//               mux, decode-error response, access watchdog and error log.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_interconnect #(
    parameter int              NUM_SLAVES  = 4,
    parameter int              AW          = 32,
    parameter int              DW          = 32,
    parameter logic [AW-1:0]   BASE_ADDR   = '0,
    parameter int              REGION_BITS = 12,
    parameter int              TIMEOUT     = 16,
    parameter int              ERRW        = 8
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     M_PSEL,
    input  logic                     M_PENABLE,
    input  logic                     M_PWRITE,
    input  logic [AW-1:0]            M_PADDR,
    input  logic [DW-1:0]            M_PWDATA,
    input  logic [DW/8-1:0]          M_PSTRB,
    input  logic [2:0]               M_PPROT,
    output logic                     M_PREADY,
    output logic [DW-1:0]            M_PRDATA,
    output logic                     M_PSLVERR,
    output logic [NUM_SLAVES-1:0]    S_PSEL,
    output logic                     S_PENABLE,
    output logic                     S_PWRITE,
    output logic [AW-1:0]            S_PADDR,
    output logic [DW-1:0]            S_PWDATA,
    output logic [DW/8-1:0]          S_PSTRB,
    output logic [2:0]               S_PPROT,
    input  logic [NUM_SLAVES-1:0]    S_PREADY,
    input  logic [NUM_SLAVES-1:0]    S_PSLVERR,
    input  logic [NUM_SLAVES*DW-1:0] S_PRDATA,
    output logic [ERRW-1:0]          ERR_COUNT,
    output logic [AW-1:0]            LAST_ERR_ADDR,
    output logic [1:0]               LAST_ERR_TYPE
);

    localparam int c_IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int c_WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [NUM_SLAVES-1:0] c_ONE = NUM_SLAVES'(1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ACCESS   = 2'd1;
    localparam logic [1:0] c_ERR_RESP = 2'd2;

    localparam logic [1:0] c_ERR_NONE    = 2'b00;
    localparam logic [1:0] c_ERR_DECODE  = 2'b01;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] c_ERR_SLAVE   = 2'b11;

    logic [1:0]          r_state;
    logic [1:0]          w_next;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_mapped;
    logic [AW-1:0]       r_addr;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [ERRW-1:0]     r_err_count;
    logic [AW-1:0]       r_err_addr;
    logic [1:0]          r_err_type;

    logic [AW-1:0]       w_off;
    logic [AW-1:0]       w_idx_full;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_mapped;
    logic                w_setup;
    logic                w_sel_ready;
    logic                w_sel_err;
    logic [DW-1:0]       w_sel_rdata;
    logic                w_timeout;
    logic [1:0]          w_err_type;

    assign w_setup     = M_PSEL && !M_PENABLE;
    assign w_off       = M_PADDR - BASE_ADDR;
    assign w_idx_full  = w_off >> REGION_BITS;
    assign w_idx       = w_idx_full[c_IDX_W-1:0];
    assign w_mapped    = (M_PADDR >= BASE_ADDR) && (w_idx_full < AW'(NUM_SLAVES));

    assign w_sel_ready = S_PREADY[r_idx];
    assign w_sel_err   = S_PSLVERR[r_idx];
    assign w_sel_rdata = S_PRDATA[32'(r_idx) * DW +: DW];

    // A slave answering in the cycle the count would expire still wins
    assign w_timeout   = (TIMEOUT != 0) && r_mapped && !w_sel_ready &&
                         (r_wcnt == c_WCNT_W'(TIMEOUT - 1));

    assign S_PWRITE      = M_PWRITE;
    assign S_PADDR       = M_PADDR;
    assign S_PWDATA      = M_PWDATA;
    assign S_PSTRB       = M_PSTRB;
    assign S_PPROT       = M_PPROT;
    assign ERR_COUNT     = r_err_count;
    assign LAST_ERR_ADDR = r_err_addr;
    assign LAST_ERR_TYPE = r_err_type;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_setup) begin
                    w_next = c_ACCESS;
                end
            end
            c_ACCESS: begin
                if (!r_mapped || w_sel_ready) begin
                    w_next = c_IDLE;
                end else if (w_timeout) begin
                    w_next = c_ERR_RESP;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        S_PSEL     = '0;
        S_PENABLE  = 1'b0;
        M_PREADY   = 1'b0;
        M_PRDATA   = '0;
        M_PSLVERR  = 1'b0;
        w_err_type = c_ERR_NONE;
        case (r_state)
            c_IDLE: begin
                if (w_setup && w_mapped) begin
                    S_PSEL = c_ONE << w_idx;
                end
            end
            c_ACCESS: begin
                if (r_mapped) begin
                    S_PSEL    = c_ONE << r_idx;
                    S_PENABLE = M_PENABLE;
                    M_PREADY  = w_sel_ready;
                    if (w_sel_ready) begin
                        M_PRDATA  = w_sel_rdata;
                        M_PSLVERR = w_sel_err;
                        if (w_sel_err) begin
                            w_err_type = c_ERR_SLAVE;
                        end
                    end
                end else begin
                    M_PREADY   = 1'b1;
                    M_PSLVERR  = 1'b1;
                    w_err_type = c_ERR_DECODE;
                end
            end
            c_ERR_RESP: begin
                M_PREADY   = 1'b1;
                M_PSLVERR  = 1'b1;
                w_err_type = c_ERR_TIMEOUT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_idx       <= '0;
            r_mapped    <= 1'b0;
            r_addr      <= '0;
            r_wcnt      <= '0;
            r_err_count <= '0;
            r_err_addr  <= '0;
            r_err_type  <= c_ERR_NONE;
        end else begin
            if (r_state == c_IDLE && w_setup) begin
                r_idx    <= w_idx;
                r_mapped <= w_mapped;
                r_addr   <= M_PADDR;
                r_wcnt   <= '0;
            end else if (r_state == c_ACCESS && !w_sel_ready) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
            if (w_err_type != c_ERR_NONE) begin
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                r_err_addr <= r_addr;
                r_err_type <= w_err_type;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_interconnect.sv
//==============================================================================
// Module      : tb_apb_interconnect
// Description : Randomized self-checking bench for apb_interconnect against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_apb_interconnect;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RB = 12;
    localparam int TO = 16;
    localparam int EW = 8;
    localparam logic [AW-1:0] BASE = '0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              m_psel, m_penable, m_pwrite;
    logic [AW-1:0]     m_paddr;
    logic [DW-1:0]     m_pwdata;
    logic [DW/8-1:0]   m_pstrb;
    logic [2:0]        m_pprot;
    logic              M_PREADY, M_PSLVERR;
    logic [DW-1:0]     M_PRDATA;
    logic [NS-1:0]     S_PSEL;
    logic              S_PENABLE, S_PWRITE;
    logic [AW-1:0]     S_PADDR;
    logic [DW-1:0]     S_PWDATA;
    logic [DW/8-1:0]   S_PSTRB;
    logic [2:0]        S_PPROT;
    logic [NS-1:0]     s_pready, s_pslverr;
    logic [NS*DW-1:0]  s_prdata;
    logic [EW-1:0]     ERR_COUNT;
    logic [AW-1:0]     LAST_ERR_ADDR;
    logic [1:0]        LAST_ERR_TYPE;

    apb_interconnect #(
        .NUM_SLAVES(NS), .AW(AW), .DW(DW), .BASE_ADDR(BASE),
        .REGION_BITS(RB), .TIMEOUT(TO), .ERRW(EW)
    ) dut (
        .PCLK(clk), .PRESET(rst),
        .M_PSEL(m_psel), .M_PENABLE(m_penable), .M_PWRITE(m_pwrite),
        .M_PADDR(m_paddr), .M_PWDATA(m_pwdata), .M_PSTRB(m_pstrb), .M_PPROT(m_pprot),
        .M_PREADY(M_PREADY), .M_PRDATA(M_PRDATA), .M_PSLVERR(M_PSLVERR),
        .S_PSEL(S_PSEL), .S_PENABLE(S_PENABLE), .S_PWRITE(S_PWRITE),
        .S_PADDR(S_PADDR), .S_PWDATA(S_PWDATA), .S_PSTRB(S_PSTRB), .S_PPROT(S_PPROT),
        .S_PREADY(s_pready), .S_PSLVERR(s_pslverr), .S_PRDATA(s_prdata),
        .ERR_COUNT(ERR_COUNT), .LAST_ERR_ADDR(LAST_ERR_ADDR), .LAST_ERR_TYPE(LAST_ERR_TYPE)
    );

    int tests  = 0;
    int failed = 0;

    // Reference model state: expected outputs for the current cycle and error log
    logic          check_en = 1'b0;
    logic [NS-1:0] exp_psel;
    logic          exp_pen, exp_pen_chk, exp_pready, exp_pslverr;
    logic [DW-1:0] exp_prdata;
    int            err_total;
    logic [AW-1:0] exp_eaddr;
    logic [1:0]    exp_etype;

    int            acc_n = 0;
    int            last_acc_n = 0;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("s_psel", 64'(S_PSEL), 64'(exp_psel));
            if (exp_pen_chk) chk("s_penable", 64'(S_PENABLE), 64'(exp_pen));
            chk("m_pready", 64'(M_PREADY), 64'(exp_pready));
            chk("m_prdata", 64'(M_PRDATA), 64'(exp_prdata));
            chk("m_pslverr", 64'(M_PSLVERR), 64'(exp_pslverr));
            chk("s_paddr", 64'(S_PADDR), 64'(m_paddr));
            chk("s_pwdata", 64'(S_PWDATA), 64'(m_pwdata));
            chk("s_pstrb", 64'(S_PSTRB), 64'(m_pstrb));
            chk("s_pprot", 64'(S_PPROT), 64'(m_pprot));
            chk("s_pwrite", 64'(S_PWRITE), 64'(m_pwrite));
            chk("err_count", 64'(ERR_COUNT), (err_total > 255) ? 64'd255 : 64'(err_total));
            chk("last_err_addr", 64'(LAST_ERR_ADDR), 64'(exp_eaddr));
            chk("last_err_type", 64'(LAST_ERR_TYPE), 64'(exp_etype));
        end
        if (m_psel && m_penable) begin
            acc_n = acc_n + 1;
            if (M_PREADY) begin
                last_acc_n = acc_n;
                last_rdata = M_PRDATA;
                last_err   = M_PSLVERR;
                acc_n      = 0;
            end
        end else begin
            acc_n = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        s_pready  = NS'($urandom);
        s_pslverr = NS'($urandom);
        s_prdata  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic log_err(input logic [1:0] t, input logic [AW-1:0] a);
        err_total++;
        exp_eaddr = a;
        exp_etype = t;
    endtask

    task automatic set_idle_exp();
        exp_psel = '0; exp_pen = 1'b0; exp_pen_chk = 1'b1;
        exp_pready = 1'b0; exp_prdata = '0; exp_pslverr = 1'b0;
    endtask

    task automatic idle();
        m_psel = 1'b0; m_penable = 1'b0;
        m_paddr = $urandom; m_pwdata = $urandom; m_pwrite = 1'($urandom);
        noise();
        set_idle_exp();
        step();
    endtask

    // waits = number of PREADY-low access cycles the slave inserts
    task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [3:0] strb,
                        input int waits, input logic serr, input logic [DW-1:0] rdata,
                        input int rst_at);
        logic          mapped, rdy;
        int            idx;
        logic [NS-1:0] oh;
        bit            done;
        mapped = (addr >= BASE) && (((addr - BASE) >> RB) < NS);
        idx    = mapped ? int'((addr - BASE) >> RB) : 0;
        oh     = mapped ? NS'(1 << idx) : '0;
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = addr;
        m_pwdata = $urandom; m_pstrb = strb; m_pprot = 3'($urandom);
        noise();
        set_idle_exp();
        exp_psel = oh;
        step();
        m_penable = 1'b1;
        if (!mapped) begin
            noise();
            exp_psel = '0; exp_pen_chk = 1'b0;
            exp_pready = 1'b1; exp_pslverr = 1'b1; exp_prdata = '0;
            step();
            log_err(2'b01, addr);
        end else begin
            done = 1'b0;
            for (int k = 1; k <= TO + 1 && !done; k++) begin
                noise();
                if (k <= TO) begin
                    rdy = (k == waits + 1);
                    s_pready[idx] = rdy;
                    s_prdata[idx*DW +: DW] = rdata;
                    if (rdy) s_pslverr[idx] = serr;
                    exp_psel = oh; exp_pen = 1'b1; exp_pen_chk = 1'b1;
                    exp_pready = rdy; exp_prdata = rdy ? rdata : '0; exp_pslverr = rdy & serr;
                    if (k == rst_at) rst = 1'b1;
                    step();
                    if (k == rst_at) begin
                        rst = 1'b0;
                        err_total = 0; exp_eaddr = '0; exp_etype = 2'b00;
                        done = 1'b1;
                    end else if (rdy) begin
                        done = 1'b1;
                        if (serr) log_err(2'b11, addr);
                    end
                end else begin
                    exp_psel = '0; exp_pen = 1'b0; exp_pen_chk = 1'b1;
                    exp_pready = 1'b1; exp_pslverr = 1'b1; exp_prdata = '0;
                    step();
                    log_err(2'b10, addr);
                    done = 1'b1;
                end
            end
        end
        m_psel = 1'b0; m_penable = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        logic [AW-1:0] a;
        int            r, w;
        rst = 1'b1;
        m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = '0;
        m_pwdata = '0; m_pstrb = '0; m_pprot = '0;
        s_pready = '0; s_pslverr = '0; s_prdata = '0;
        err_total = 0; exp_eaddr = '0; exp_etype = 2'b00;
        set_idle_exp();
        step();
        check_en = 1'b1;
        step();
        rst = 1'b0;
        chk("lit_rst_count", 64'(ERR_COUNT), 64'd0);
        chk("lit_rst_type", 64'(LAST_ERR_TYPE), 64'd0);
        idle();

        xfer(32'h1004, 1'b0, 4'hF, 0, 1'b0, 32'hCAFE, 0);
        chk("lit_cafe_rdata", 64'(last_rdata), 64'hCAFE);
        chk("lit_cafe_cycles", 64'(last_acc_n), 64'd1);
        chk("lit_cafe_err", 64'(last_err), 64'd0);
        idle();

        xfer(32'h3000, 1'b1, 4'b0011, 3, 1'b0, 32'h0, 0);
        chk("lit_wait3_cycles", 64'(last_acc_n), 64'd4);
        chk("lit_wait3_count", 64'(ERR_COUNT), 64'd0);
        idle();

        xfer(32'h4000, 1'b0, 4'hF, 0, 1'b0, 32'h0, 0);
        chk("lit_dec_count", 64'(ERR_COUNT), 64'd1);
        chk("lit_dec_type", 64'(LAST_ERR_TYPE), 64'b01);
        chk("lit_dec_addr", 64'(LAST_ERR_ADDR), 64'h4000);
        idle();

        xfer(32'h2010, 1'b0, 4'hF, 100, 1'b0, 32'h0, 0);
        chk("lit_to_cycles", 64'(last_acc_n), 64'd17);
        chk("lit_to_err", 64'(last_err), 64'd1);
        chk("lit_to_type", 64'(LAST_ERR_TYPE), 64'b10);
        chk("lit_to_count", 64'(ERR_COUNT), 64'd2);

        xfer(32'h2010, 1'b0, 4'hF, 15, 1'b0, 32'h1234, 0);
        chk("lit_edge_cycles", 64'(last_acc_n), 64'd16);
        chk("lit_edge_rdata", 64'(last_rdata), 64'h1234);
        chk("lit_edge_count", 64'(ERR_COUNT), 64'd2);

        xfer(32'h0008, 1'b0, 4'hF, 1, 1'b1, 32'h55, 0);
        chk("lit_slverr_type", 64'(LAST_ERR_TYPE), 64'b11);
        chk("lit_slverr_count", 64'(ERR_COUNT), 64'd3);

        xfer(32'h1000, 1'b0, 4'hF, 100, 1'b0, 32'h0, 2);
        idle();
        chk("lit_midrst_count", 64'(ERR_COUNT), 64'd0);
        chk("lit_midrst_addr", 64'(LAST_ERR_ADDR), 64'd0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) a = (AW'($urandom_range(0, NS - 1)) << RB) | AW'($urandom_range(0, 4095));
            else if (r < 9) a = $urandom_range(32'h4000, 32'hFFFF_FFFF);
            else a = $urandom;
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
            xfer(a, 1'($urandom), 4'($urandom), w, ($urandom_range(0, 3) == 0), $urandom, 0);
            if ($urandom_range(0, 1) == 1) idle();
        end

        for (int n = 0; n < 260; n++) begin
            xfer(32'h4000 + 32'($urandom_range(0, 32'h0FFF_FFFF)), 1'b0, 4'hF, 0, 1'b0, 32'h0, 0);
        end
        idle();
        chk("lit_sat_count", 64'(ERR_COUNT), 64'd255);
        chk("lit_sat_type", 64'(LAST_ERR_TYPE), 64'b01);
        idle();

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
